// File: rtl/processor_pkg.sv
// processor_pkg: shared types and constants for the 5-stage LEGv8-subset core.
// Holds opcode constants, the ALU-op enum, the control bundle, the pipeline
// register layouts, the default program image and the ALU helper.
package processor_pkg;

  // ADD XZR,XZR,XZR: what the core fetches outside the ROM image
  localparam logic [31:0] NOP_INSTR = 32'h8B1F03FF;

  // Full 11-bit opcodes
  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;
  // Shorter opcodes, compared against the top bits of the 11-bit field
  localparam logic [9:0]  OP_ADDI = 10'h244;  // 0x488-0x489
  localparam logic [7:0]  OP_CBZ  = 8'hB4;    // 0x5A0-0x5A7
  localparam logic [5:0]  OP_B    = 6'h05;    // 0x0A0-0x0BF

  // Program 1, word 0 in the least significant 32 bits
  localparam int PROG1_WORDS = 8;
  localparam logic [PROG1_WORDS*32-1:0] PROG1 = {
    32'h14000000,  // 0x1C B .
    32'hB40000A5,  // 0x18 CBZ X5,+5
    32'hCB020085,  // 0x14 SUB X5,X4,X2
    32'hF84003E4,  // 0x10 LDUR X4,[XZR,#0]
    32'hF80003E3,  // 0x0C STUR X3,[XZR,#0]
    32'h8B020023,  // 0x08 ADD X3,X1,X2
    32'h910007E2,  // 0x04 ADDI X2,XZR,#1
    32'h91003FE1   // 0x00 ADDI X1,XZR,#15
  };

  // ALU_ADD is encoding 0 so an all-zero bubble computes 0+0
  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_ORR   = 3'd3,
    ALU_PASSB = 3'd4
  } alu_op_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    alu_src;
    logic    branch;
    logic    uncond;
    alu_op_e alu_op;
  } ctrl_t;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } if_id_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [63:0] pc;
    logic [63:0] rd1;
    logic [63:0] rd2;
    logic [63:0] imm;
    logic [4:0]  rn;
    logic [4:0]  r2;
    logic [4:0]  rd;
  } id_ex_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [63:0] alu_result;
    logic [63:0] store_data;
    logic [4:0]  rd;
  } ex_mem_t;

  typedef struct packed {
    ctrl_t       ctrl;
    logic [63:0] alu_result;
    logic [63:0] load_data;
    logic [4:0]  rd;
  } mem_wb_t;

  // 64-bit wrap-around ALU, no flags
  function automatic logic [63:0] alu_calc(input alu_op_e op, input logic [63:0] a,
                                           input logic [63:0] b);
    logic [63:0] r;
    case (op)
      ALU_SUB:   r = a - b;
      ALU_AND:   r = a & b;
      ALU_ORR:   r = a | b;
      ALU_PASSB: r = b;
      default:   r = a + b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/processor_regfile.sv
// processor_regfile: 32x64 register file, two combinational read ports and one
// write port. X31 reads as zero and is never written. A read of the register
// being written this cycle returns the incoming value (write-through).
module processor_regfile
  import processor_pkg::*;
(
  input  logic             CLK,
  input  logic [1:0][4:0]  rd_addr,
  output logic [1:0][63:0] rd_data,
  input  logic             wr_en,
  input  logic [4:0]       wr_addr,
  input  logic [63:0]      wr_data
);

  logic [63:0] regs_mem [32];

  // architectural write; X31 is a hard zero so its slot is left untouched
  always_ff @(posedge CLK) begin
    if (wr_en && (wr_addr != 5'd31)) begin
      regs_mem[wr_addr] <= wr_data;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      // read port with zero register and same-cycle write-through
      always_comb begin
        rd_data[gi] = regs_mem[rd_addr[gi]];
        if (rd_addr[gi] == 5'd31) begin
          rd_data[gi] = '0;
        end else if (wr_en && (wr_addr == rd_addr[gi])) begin
          rd_data[gi] = wr_data;
        end
      end
    end
  endgenerate

endmodule

// File: rtl/processor.sv
// processor: 5-stage (IF/ID/EX/MEM/WB) 64-bit LEGv8-subset core with internal
// instruction ROM, data RAM and register file. Branches resolve in EX with
// not-taken prediction; load-use costs one bubble. Defining PROCCESOR_TRACE_EN
// prints every architectural register write-back with a cycle count.
module processor
  import processor_pkg::*;
#(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 32,
  parameter int PROG_WORDS = PROG1_WORDS,
  parameter logic [PROG_WORDS*32-1:0] PROG = PROG1
) (
  input  logic        CLK,
  input  logic        resetl,
  input  logic [63:0] startpc,
  output logic [63:0] currentpc,
  output logic [63:0] MemtoRegOut
);

  localparam int IA_W = $clog2(IMEM_WORDS);
  localparam int DA_W = $clog2(DMEM_WORDS);

  logic [63:0] pc_reg, pc_next;
  if_id_t      if_id_reg, if_id_next;
  id_ex_t      id_ex_reg, id_ex_next, id_ex_dec;
  ex_mem_t     ex_mem_reg, ex_mem_next;
  mem_wb_t     mem_wb_reg, mem_wb_next;

  // ---------------- IF ----------------
  logic [31:0] rom [IMEM_WORDS];
  logic [31:0] fetch_instr;

  genvar gi;
  generate
    for (gi = 0; gi < IMEM_WORDS; gi++) begin : g_rom
      if (gi < PROG_WORDS) begin : g_prog
        assign rom[gi] = PROG[gi*32 +: 32];
      end else begin : g_fill
        assign rom[gi] = NOP_INSTR;
      end
    end
  endgenerate

  // combinational fetch; anything past the ROM returns a NOP
  always_comb begin
    fetch_instr = NOP_INSTR;
    if (pc_reg[63:2] < 62'(IMEM_WORDS)) begin
      fetch_instr = rom[pc_reg[2 +: IA_W]];
    end
  end

  assign currentpc = pc_reg;

  // ---------------- ID ----------------
  logic [31:0]      id_instr;
  logic [10:0]      id_opcode;
  ctrl_t            id_ctrl;
  logic             id_known, id_use_rn, id_use_r2;
  logic [4:0]       id_rn, id_r2, id_rd;
  logic [63:0]      id_imm;
  logic [1:0][63:0] id_rdata;
  logic [63:0]      wb_data;
  logic             wb_reg_write;
  logic [4:0]       wb_rd;
  logic             load_use_stall;

  // decode: control bundle, immediate and source registers; unused sources
  // are pointed at X31 so they read zero and never match a forwarding path
  always_comb begin
    id_instr  = if_id_reg.instr;
    id_opcode = id_instr[31:21];
    id_ctrl   = '0;
    id_known  = 1'b0;
    id_use_rn = 1'b0;
    id_use_r2 = 1'b0;
    id_imm    = '0;
    id_rd     = id_instr[4:0];
    id_rn     = 5'd31;
    id_r2     = 5'd31;
    case (id_opcode)
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        id_known          = 1'b1;
        id_use_rn         = 1'b1;
        id_use_r2         = 1'b1;
        id_ctrl.reg_write = 1'b1;
        id_ctrl.alu_op    = (id_opcode == OP_SUB) ? ALU_SUB :
                            (id_opcode == OP_AND) ? ALU_AND :
                            (id_opcode == OP_ORR) ? ALU_ORR : ALU_ADD;
      end
      OP_LDUR: begin
        id_known           = 1'b1;
        id_use_rn          = 1'b1;
        id_ctrl.reg_write  = 1'b1;
        id_ctrl.mem_read   = 1'b1;
        id_ctrl.mem_to_reg = 1'b1;
        id_ctrl.alu_src    = 1'b1;
        id_imm             = {{55{id_instr[20]}}, id_instr[20:12]};
      end
      OP_STUR: begin
        id_known          = 1'b1;
        id_use_rn         = 1'b1;
        id_use_r2         = 1'b1;
        id_ctrl.mem_write = 1'b1;
        id_ctrl.alu_src   = 1'b1;
        id_imm            = {{55{id_instr[20]}}, id_instr[20:12]};
      end
      default: begin
        if (id_opcode[10:1] == OP_ADDI) begin
          id_known          = 1'b1;
          id_use_rn         = 1'b1;
          id_ctrl.reg_write = 1'b1;
          id_ctrl.alu_src   = 1'b1;
          id_imm            = {52'd0, id_instr[21:10]};
        end else if (id_opcode[10:3] == OP_CBZ) begin
          id_known       = 1'b1;
          id_use_r2      = 1'b1;
          id_ctrl.branch = 1'b1;
          id_ctrl.alu_op = ALU_PASSB;
          id_imm         = {{43{id_instr[23]}}, id_instr[23:5], 2'b00};
        end else if (id_opcode[10:5] == OP_B) begin
          id_known        = 1'b1;
          id_ctrl.branch  = 1'b1;
          id_ctrl.uncond  = 1'b1;
          id_ctrl.alu_src = 1'b1;
          id_ctrl.alu_op  = ALU_PASSB;
          id_imm          = {{36{id_instr[25]}}, id_instr[25:0], 2'b00};
        end
      end
    endcase
    if (id_use_rn) id_rn = id_instr[9:5];
    if (id_use_r2) id_r2 = (id_ctrl.mem_write || id_ctrl.branch) ? id_instr[4:0]
                                                                   : id_instr[20:16];
  end

  processor_regfile u_regfile (
    .CLK     (CLK),
    .rd_addr ({id_r2, id_rn}),
    .rd_data (id_rdata),
    .wr_en   (wb_reg_write),
    .wr_addr (wb_rd),
    .wr_data (wb_data)
  );

  // assemble the ID/EX word; unrecognised opcodes become a clean bubble
  always_comb begin
    id_ex_dec = '{ctrl: id_ctrl, pc: if_id_reg.pc, rd1: id_rdata[0], rd2: id_rdata[1],
                  imm: id_imm, rn: id_rn, r2: id_r2, rd: id_rd};
    if (!id_known) id_ex_dec = '0;
  end

  assign load_use_stall = id_ex_reg.ctrl.mem_read && (id_ex_reg.rd != 5'd31) &&
                          ((id_rn == id_ex_reg.rd) || (id_r2 == id_ex_reg.rd));

  // ---------------- EX ----------------
  logic [1:0][4:0]  ex_src;
  logic [1:0][63:0] ex_src_val, ex_fwd;
  logic [63:0]      ex_alu_b, ex_result, branch_target;
  logic             branch_taken;

  assign ex_src     = {id_ex_reg.r2, id_ex_reg.rn};
  assign ex_src_val = {id_ex_reg.rd2, id_ex_reg.rd1};

  generate
    for (gi = 0; gi < 2; gi++) begin : g_fwd
      // operand forwarding: the younger EX/MEM result wins over MEM/WB
      always_comb begin
        ex_fwd[gi] = ex_src_val[gi];
        if (ex_mem_reg.ctrl.reg_write && (ex_mem_reg.rd != 5'd31) &&
            (ex_mem_reg.rd == ex_src[gi])) begin
          ex_fwd[gi] = ex_mem_reg.alu_result;
        end else if (mem_wb_reg.ctrl.reg_write && (mem_wb_reg.rd != 5'd31) &&
                     (mem_wb_reg.rd == ex_src[gi])) begin
          ex_fwd[gi] = wb_data;
        end
      end
    end
  endgenerate

  // ALU, branch decision and target
  always_comb begin
    ex_alu_b      = id_ex_reg.ctrl.alu_src ? id_ex_reg.imm : ex_fwd[1];
    ex_result     = alu_calc(id_ex_reg.ctrl.alu_op, ex_fwd[0], ex_alu_b);
    branch_taken  = id_ex_reg.ctrl.branch && (id_ex_reg.ctrl.uncond || (ex_fwd[1] == '0));
    branch_target = id_ex_reg.pc + id_ex_reg.imm;
    ex_mem_next   = '{ctrl: id_ex_reg.ctrl, alu_result: ex_result,
                      store_data: ex_fwd[1], rd: id_ex_reg.rd};
  end

  // ---------------- MEM ----------------
  logic [63:0]     dmem [DMEM_WORDS];
  logic [DA_W-1:0] mem_addr;

  assign mem_addr = ex_mem_reg.alu_result[3 +: DA_W];

  // store port; upper address bits are dropped so addresses wrap
  always_ff @(posedge CLK) begin
    if (ex_mem_reg.ctrl.mem_write) begin
      dmem[mem_addr] <= ex_mem_reg.store_data;
    end
  end

  assign mem_wb_next = '{ctrl: ex_mem_reg.ctrl, alu_result: ex_mem_reg.alu_result,
                         load_data: dmem[mem_addr], rd: ex_mem_reg.rd};

  // ---------------- WB ----------------
  assign wb_data      = mem_wb_reg.ctrl.mem_to_reg ? mem_wb_reg.load_data : mem_wb_reg.alu_result;
  assign wb_reg_write = mem_wb_reg.ctrl.reg_write;
  assign wb_rd        = mem_wb_reg.rd;
  assign MemtoRegOut  = wb_data;

  logic unused_wb_ctrl;
  assign unused_wb_ctrl = ^mem_wb_reg.ctrl;

  // front-end steering: a taken branch beats a load-use hold, else PC+4
  always_comb begin
    pc_next    = pc_reg + 64'd4;
    if_id_next = '{pc: pc_reg, instr: fetch_instr};
    id_ex_next = id_ex_dec;
    if (branch_taken) begin
      pc_next    = branch_target;
      if_id_next = '0;
      id_ex_next = '0;
    end else if (load_use_stall) begin
      pc_next    = pc_reg;
      if_id_next = if_id_reg;
      id_ex_next = '0;
    end
  end

  // pipeline registers; reset loads startpc and empties every stage
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      pc_reg     <= startpc;
      if_id_reg  <= '0;
      id_ex_reg  <= '0;
      ex_mem_reg <= '0;
      mem_wb_reg <= '0;
    end else begin
      pc_reg     <= pc_next;
      if_id_reg  <= if_id_next;
      id_ex_reg  <= id_ex_next;
      ex_mem_reg <= ex_mem_next;
      mem_wb_reg <= mem_wb_next;
    end
  end

`ifdef PROCCESOR_TRACE_EN
  logic [63:0] cycle_count_reg;

  // cycle counter and write-back trace
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      cycle_count_reg <= '0;
    end else begin
      cycle_count_reg <= cycle_count_reg + 64'd1;
      if (wb_reg_write && (wb_rd != 5'd31)) begin
        $display("trace: X%0d <= 0x%016h @ cycle %0d", wb_rd, wb_data, cycle_count_reg);
      end
    end
  end
`endif

endmodule

// File: tb/tb_processor.sv
// tb_processor: directed-vector bench. dut runs program 1, dut2 runs a small
// branch program; per-edge PC and write-back vectors are hand-derived.
module tb_processor;

  logic        CLK;
  logic        resetl;
  logic [63:0] startpc;
  logic [63:0] pc_a, out_a, pc_b, out_b;

  int n_vec;
  int n_miss;

  localparam logic [6*32-1:0] PROG_BR = {
    32'h14000000,  // 0x14 B .
    32'h91000FE8,  // 0x10 ADDI X8,XZR,#3
    32'h910027E7,  // 0x0C ADDI X7,XZR,#9 (wrong path)
    32'h91001FE6,  // 0x08 ADDI X6,XZR,#7 (wrong path)
    32'hB4000061,  // 0x04 CBZ X1,+3 -> 0x10
    32'h910003E1   // 0x00 ADDI X1,XZR,#0
  };

  processor dut (
    .CLK(CLK), .resetl(resetl), .startpc(startpc),
    .currentpc(pc_a), .MemtoRegOut(out_a)
  );

  processor #(.PROG_WORDS(6), .PROG(PROG_BR)) dut2 (
    .CLK(CLK), .resetl(resetl), .startpc(startpc),
    .currentpc(pc_b), .MemtoRegOut(out_b)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Program 1, edges 1..16 after reset release
  logic [63:0] exp_pc_a [16] = '{64'h04, 64'h08, 64'h0C, 64'h10, 64'h14, 64'h18, 64'h18, 64'h1C,
                                 64'h20, 64'h24, 64'h1C, 64'h20, 64'h24, 64'h1C, 64'h20, 64'h24};
  logic        exp_we_a [16] = '{0, 0, 0, 1, 1, 1, 0, 1, 0, 1, 0, 0, 0, 0, 0, 0};
  logic [4:0]  exp_rd_a [16] = '{0, 0, 0, 1, 2, 3, 0, 4, 0, 5, 0, 0, 0, 0, 0, 0};
  logic        chk_wb_a [16] = '{1, 1, 1, 1, 1, 1, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0};
  logic [63:0] exp_wb_a [16] = '{64'h0, 64'h0, 64'h0, 64'hF, 64'h1, 64'h10, 64'h0, 64'h10,
                                 64'h0, 64'hF, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0};
  // Branch program, edges 1..9
  logic [63:0] exp_pc_b [9] = '{64'h04, 64'h08, 64'h0C, 64'h10, 64'h14, 64'h18, 64'h1C, 64'h14, 64'h18};
  logic        exp_we_b [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
  logic [4:0]  exp_rd_b [9] = '{0, 0, 0, 1, 0, 0, 0, 8, 0};
  logic [63:0] exp_wb_b [9] = '{64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h0, 64'h3, 64'h0};

  task automatic check_vec(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%016h", tag, got);
    end
  endtask

  initial begin
    n_vec   = 0;
    n_miss  = 0;
    startpc = 64'h0;
    resetl  = 1'b0;

    // reset state
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_vec("reset pc", pc_a, 64'h0);
    check_vec("reset wb", out_a, 64'h0);
    check_vec("first fetch", {32'h0, dut.fetch_instr}, 64'h91003FE1);
    check_vec("dut2 first fetch", {32'h0, dut2.fetch_instr}, 64'h910003E1);
    resetl = 1'b1;

    // per-edge vectors for both programs
    for (int e = 0; e < 16; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_vec($sformatf("p1 pc e%0d", e + 1), pc_a, exp_pc_a[e]);
      check_vec($sformatf("p1 we e%0d", e + 1), {63'h0, dut.wb_reg_write}, {63'h0, exp_we_a[e]});
      if (exp_we_a[e])
        check_vec($sformatf("p1 rd e%0d", e + 1), {59'h0, dut.wb_rd}, {59'h0, exp_rd_a[e]});
      if (chk_wb_a[e])
        check_vec($sformatf("p1 wb e%0d", e + 1), out_a, exp_wb_a[e]);
      if (e < 9) begin
        check_vec($sformatf("br pc e%0d", e + 1), pc_b, exp_pc_b[e]);
        check_vec($sformatf("br we e%0d", e + 1), {63'h0, dut2.wb_reg_write}, {63'h0, exp_we_b[e]});
        if (exp_we_b[e]) begin
          check_vec($sformatf("br rd e%0d", e + 1), {59'h0, dut2.wb_rd}, {59'h0, exp_rd_b[e]});
          check_vec($sformatf("br wb e%0d", e + 1), out_b, exp_wb_b[e]);
        end
      end
    end

    // architectural state after program 1 reaches its self-loop
    check_vec("X1", dut.u_regfile.regs_mem[1], 64'hF);
    check_vec("X2", dut.u_regfile.regs_mem[2], 64'h1);
    check_vec("X3", dut.u_regfile.regs_mem[3], 64'h10);
    check_vec("mem[0]", dut.dmem[0], 64'h10);
    check_vec("X4", dut.u_regfile.regs_mem[4], 64'h10);
    check_vec("X5", dut.u_regfile.regs_mem[5], 64'hF);
    check_vec("dut2 X8", dut2.u_regfile.regs_mem[8], 64'h3);

    // mid-program asynchronous reset with a new start PC
    startpc = 64'h8;
    #1 resetl = 1'b0;
    #1;
    check_vec("async reset pc", pc_a, 64'h8);
    check_vec("async reset wb", out_a, 64'h0);
    check_vec("async reset we", {63'h0, dut.wb_reg_write}, 64'h0);
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    check_vec("held reset pc", pc_a, 64'h8);
    resetl = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge CLK);
      @(negedge CLK);
      check_vec($sformatf("rst pc e%0d", e), pc_a, 64'h8 + 64'(4 * e));
      check_vec($sformatf("rst wb e%0d", e), out_a, (e == 4) ? 64'h10 : 64'h0);
      check_vec($sformatf("rst we e%0d", e), {63'h0, dut.wb_reg_write}, (e == 4) ? 64'h1 : 64'h0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/processor.md
Name: processor

Overview:
- 5-stage pipelined 64-bit LEGv8-subset CPU: IF, ID, EX, MEM, WB.
- Internal instruction ROM, data RAM and register file; the core is self-contained.
- Exposes the fetch PC and the write-back data for top-level program checking.
- Program start is set by startpc, which is loaded while reset is asserted.

Parameters:
- IMEM_WORDS, 64, instruction ROM depth in 32-bit words.
- DMEM_WORDS, 32, data RAM depth in 64-bit doublewords.

Ports:
- CLK  in  1  single rising-edge clock.
- resetl  in  1  asynchronous, active-low reset.
- startpc  in  64  PC loaded during reset.
- currentpc  out  64  current IF-stage PC.
- MemtoRegOut  out  64  WB-stage result: the load data when MemtoReg=1, otherwise the ALU result; driven even if RegWrite=0.

Behaviour:
Interface (already decided):
- One clock, CLK.
- Reset resetl is asynchronous and active-low.

Reset (resetl=0):
- PC <= startpc.
- All pipeline registers cleared to bubbles (all control bits 0).
- MemtoRegOut = 0.
- Register file X0..X30 and data RAM are not cleared.
- Reset asserted mid-program aborts all in-flight instructions; nothing writes back.

Fetch and PC:
- ROM read is combinational, word index PC[2+:6].
- Out-of-range PC fetches a NOP (0x8B1F03FF, ADD XZR,XZR,XZR).
- PC update priority: taken branch > load-use stall > PC+4.

Registers:
- X31 reads as 0; writes to X31 are ignored.
- Write in WB on the first half-cycle; a read in ID of the same register returns the new value (write-through bypass).

Supported ISA:
- R-type: ADD 0x458, SUB 0x658, AND 0x450, ORR 0x550.
- ADDI 0x488-0x489: imm12 zero-extended.
- LDUR 0x7C2, STUR 0x7C0: D-type imm9 sign-extended; address = Xn + imm.
- CBZ 0x5A0-0x5A7: imm19 sign-extended, <<2.
- B 0x0A0-0x0BF: imm26 sign-extended, <<2.
- Any unrecognised opcode executes as a NOP.

Execute:
- 64-bit ALU, wrap-around on overflow, no flags.
- Forwarding into EX: priority EX/MEM over MEM/WB; never forward X31.

Branches:
- Resolved in EX; target = branch PC + offset.
- On a taken branch (B, or CBZ with forwarded Rt == 0), the IF/ID and ID/EX contents are flushed to bubbles.
- Not-taken prediction, so a taken branch costs 2 cycles.

Load-use hazard:
- Condition: the ID instruction reads the Rd of a LDUR currently in EX.
- PC and IF/ID hold; a bubble is inserted into EX; 1 cycle.

Memory:
- Data RAM is doubleword-addressed via addr[3+:5]; the upper address bits are ignored, so addresses wrap.
- Synchronous write in MEM; asynchronous read.

Timing:
- The instruction fetched at PC p presents its result on MemtoRegOut 4 rising edges later, absent stalls.

Default ROM (program 1); all remaining words are NOP:
- 0x00: 0x91003FE1  ADDI X1,XZR,#15
- 0x04: 0x910007E2  ADDI X2,XZR,#1
- 0x08: 0x8B020023  ADD X3,X1,X2 (=16)
- 0x0C: 0xF80003E3  STUR X3,[XZR,#0]
- 0x10: 0xF84003E4  LDUR X4,[XZR,#0]
- 0x14: 0xCB020085  SUB X5,X4,X2 (=15)
- 0x18: 0xB40000A5  CBZ X5,+5 (not taken)
- 0x1C: 0x14000000  B . (self-loop; end)

Optional Feature:
- Macro PROCCESOR_TRACE_EN.
- Defined: every WB with RegWrite=1 and Rd≠31 prints, via $display, the register number, the value and the cycle count.
- Not defined: no trace output, and no simulation-only constructs beyond ROM init.

Decomposition:
- Package processor_pkg holds:
  - opcode constants;
  - ALU-op enum (ADD/SUB/AND/ORR/PASSB);
  - control-bundle struct (RegWrite, MemRead, MemWrite, MemtoReg, ALUSrc, Branch, Uncond, ALUOp);
  - pipeline-register structs;
  - the NOP constant.
- Sub-module processor_regfile (32x64, 2R/1W, X31=0, write-through bypass); everything else inline.

Test Plan:
- Reset with startpc=0, release after 2 edges -> currentpc=0x0; the first fetch is 0x91003FE1.
- Run until currentpc ≥ 0x10 (sample at negedge) -> MemtoRegOut=0x000000000000000F (ADDI X1 in WB).
- Continue to the self-loop -> X3=0x10, mem[0]=0x10, X4=0x10 (load-use stall inserted before SUB), X5=0xF.
- At the self-loop B at 0x1C -> currentpc repeatedly returns to 0x1C; no instruction after it ever writes back.
- Custom ROM: ADDI X1,XZR,#0 then CBZ X1,+3 -> PC jumps to the target; the 2 wrong-path instructions do not write back.
- Assert resetl low mid-program with startpc=0x8 -> currentpc=0x8 immediately (async); MemtoRegOut=0 until new results reach WB.
